alu_mem_datapath: RTL and testbench

//  Processor datapath core: instruction memory (IM), 16-bit ALU and data memory (DM) with stack port.
//  IM is written word-by-word during program load and read combinationally by PC.
//  ALU opcode/immediate decoded from the fetched word. DM serves STA/LDA, PSH/POP and RET.

---
 rtl/alu_mem_datapath.sv | 151 +++++++++++++++
 tb/tb_alu_mem_datapath.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_datapath.sv
`default_nettype none
// ============================================================================
// Module      : alu_mem_datapath
// Description : Processor datapath core. It contains an instruction memory
//               that is loaded word by word and read combinationally, a
//               16-bit ALU decoded from the fetched word, and a data memory
//               with a stack port.
//               Optional build macro ALU_SHIFT_EN enables the LSL/LSR opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mem_datapath #(
   parameter int IM_DEPTH = 1024,
   parameter int DM_DEPTH = 512
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        im_en_write,
   input  logic [9:0]  im_address,
   input  logic [15:0] im_data_in,
   output logic [15:0] instruction,
   input  logic [15:0] alu_a,
   input  logic        alu_store,
   output logic [15:0] alu_out,
   output logic [3:0]  alu_flags,
   output logic [3:0]  alu_flags_q,
   input  logic        dm_store,
   input  logic        dm_push,
   input  logic        dm_pop,
   input  logic        dm_wsel,
   input  logic [15:0] dm_wdata,
   input  logic [15:0] sp,
   output logic [15:0] dm_out
);

   localparam int DM_AW = $clog2(DM_DEPTH);

   localparam logic [5:0] OP_MOV = 6'b010000;
   localparam logic [5:0] OP_ADD = 6'b010001;
   localparam logic [5:0] OP_SUB = 6'b010010;
   localparam logic [5:0] OP_NOT = 6'b010011;
   localparam logic [5:0] OP_AND = 6'b010100;
   localparam logic [5:0] OP_OR  = 6'b010101;
   localparam logic [5:0] OP_XOR = 6'b010110;
`ifdef ALU_SHIFT_EN
   localparam logic [5:0] OP_LSL = 6'b010111;
   localparam logic [5:0] OP_LSR = 6'b011000;
`endif

   logic [15:0]      im_mem [IM_DEPTH];
   logic [15:0]      dm_mem [DM_DEPTH];

   logic [5:0]       op;
   logic [15:0]      imm_b;
   logic [16:0]      sum;
   logic [16:0]      dif;
   logic             carry;
   logic             ovf;
   logic             dm_we;
   logic [DM_AW-1:0] dm_waddr;
   logic [15:0]      dm_wdat;
   logic             unused_bits;

   // Upper stack pointer bits and instruction bit 9 carry no meaning here.
   assign unused_bits = ^{sp[15:DM_AW], instruction[9]};

   // Program memory: survives reset, new word visible after the write edge.
   always_ff @(posedge clk) begin
      if (im_en_write) begin
         im_mem[im_address] <= im_data_in;
      end
   end

   assign instruction = im_mem[im_address];

   assign op    = instruction[15:10];
   assign imm_b = {{7{instruction[8]}}, instruction[8:0]};
   assign sum   = {1'b0, alu_a} + {1'b0, imm_b};
   assign dif   = {1'b0, alu_a} - {1'b0, imm_b};

`ifdef ALU_SHIFT_EN
   logic [16:0] shl;
   logic [16:0] shr;
   // Extra top/bottom bit catches the last bit shifted out (0 for a zero shift).
   assign shl = {1'b0, alu_a} << imm_b[3:0];
   assign shr = {alu_a, 1'b0} >> imm_b[3:0];
`endif

   // ALU result and carry/overflow; store pass-through overrides the opcode.
   always_comb begin
      alu_out = '0;
      carry   = 1'b0;
      ovf     = 1'b0;
      if (alu_store) begin
         alu_out = alu_a;
      end else begin
         case (op)
            OP_MOV: alu_out = imm_b;
            OP_ADD: begin
               alu_out = sum[15:0];
               carry   = sum[16];
               ovf     = (alu_a[15] == imm_b[15]) && (sum[15] != alu_a[15]);
            end
            OP_SUB: begin
               alu_out = dif[15:0];
               carry   = dif[16];
               ovf     = (alu_a[15] != imm_b[15]) && (dif[15] != alu_a[15]);
            end
            OP_NOT: alu_out = ~alu_a;
            OP_AND: alu_out = alu_a & imm_b;
            OP_OR:  alu_out = alu_a | imm_b;
            OP_XOR: alu_out = alu_a ^ imm_b;
`ifdef ALU_SHIFT_EN
            OP_LSL: {carry, alu_out} = shl;
            OP_LSR: {alu_out, carry} = shr;
`endif
            default: alu_out = '0;
         endcase
      end
   end

   assign alu_flags = {(alu_out == 16'h0000), alu_out[15], carry, ovf};

   // Flag register captures ALU-class opcodes only, never a store pass-through.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         alu_flags_q <= '0;
      end else if ((op[5:3] == 3'b010) && !alu_store) begin
         alu_flags_q <= alu_flags;
      end
   end

   // Push owns the write port when both push and store are requested.
   assign dm_we    = dm_push | dm_store;
   assign dm_waddr = dm_push ? sp[DM_AW-1:0] : instruction[DM_AW-1:0];
   assign dm_wdat  = dm_wsel ? dm_wdata : alu_out;

   // Data memory: cleared asynchronously, written on the clock edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DM_DEPTH; i++) begin
            dm_mem[i] <= '0;
         end
      end else if (dm_we) begin
         dm_mem[dm_waddr] <= dm_wdat;
      end
   end

   assign dm_out = dm_pop ? dm_mem[sp[DM_AW-1:0]] : dm_mem[instruction[DM_AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_alu_mem_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mem_datapath
// Description : Directed self-checking bench for alu_mem_datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mem_datapath;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        im_en_write;
   logic [9:0]  im_address;
   logic [15:0] im_data_in;
   logic [15:0] instruction;
   logic [15:0] alu_a;
   logic        alu_store;
   logic [15:0] alu_out;
   logic [3:0]  alu_flags;
   logic [3:0]  alu_flags_q;
   logic        dm_store;
   logic        dm_push;
   logic        dm_pop;
   logic        dm_wsel;
   logic [15:0] dm_wdata;
   logic [15:0] sp;
   logic [15:0] dm_out;

   int checks = 0;
   int errors = 0;

   logic [15:0] prog [12];

   alu_mem_datapath dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .im_en_write (im_en_write),
      .im_address  (im_address),
      .im_data_in  (im_data_in),
      .instruction (instruction),
      .alu_a       (alu_a),
      .alu_store   (alu_store),
      .alu_out     (alu_out),
      .alu_flags   (alu_flags),
      .alu_flags_q (alu_flags_q),
      .dm_store    (dm_store),
      .dm_push     (dm_push),
      .dm_pop      (dm_pop),
      .dm_wsel     (dm_wsel),
      .dm_wdata    (dm_wdata),
      .sp          (sp),
      .dm_out      (dm_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Advance past the next rising edge and settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0; im_en_write = 1'b0; im_address = '0; im_data_in = '0;
      alu_a = '0; alu_store = 1'b0; dm_store = 1'b0; dm_push = 1'b0;
      dm_pop = 1'b0; dm_wsel = 1'b0; dm_wdata = '0; sp = '0;

      prog[0]  = 16'h400A; prog[1]  = 16'h5401; prog[2]  = 16'h5404;
      prog[3]  = 16'h500D; prog[4]  = 16'h5808; prog[5]  = 16'h0801;
      prog[6]  = 16'h0401; prog[7]  = 16'h4401; prog[8]  = 16'h4801;
      prog[9]  = 16'h5C03; prog[10] = 16'h6002; prog[11] = 16'h0000;

      #7 reset_n = 1'b1;
      step();
      // program load
      for (int i = 0; i < 12; i++) begin
         im_en_write = 1'b1; im_address = 10'(i); im_data_in = prog[i];
         step();
      end
      im_en_write = 1'b0;

      // reset pulse between edges
      #2 reset_n = 1'b0;
      #1 reset_n = 1'b1;
      im_address = 10'd0; alu_a = 16'd10;
      #1;
      chk("reset_flags_q", {12'h0, alu_flags_q}, 16'h0000);
      chk("reset_dm10", dm_out, 16'h0000);
      chk("mov_instr", instruction, 16'h400A);
      chk("mov_out", alu_out, 16'h000A);
      chk("mov_flags", {12'h0, alu_flags}, 16'h0000);

      // logic ops chain
      im_address = 10'd1; alu_a = 16'd10; #1;
      chk("or1", alu_out, 16'd11);
      im_address = 10'd2; alu_a = 16'd11; #1;
      chk("or4", alu_out, 16'd15);
      im_address = 10'd3; alu_a = 16'd15; #1;
      chk("and13", alu_out, 16'd13);
      im_address = 10'd4; alu_a = 16'd13; #1;
      chk("xor8", alu_out, 16'd5);

      // STA 1 then LDA 1
      step();
      im_address = 10'd5; alu_store = 1'b1; alu_a = 16'd10; dm_store = 1'b1; dm_wsel = 1'b0;
      #1;
      chk("sta_out", alu_out, 16'd10);
      chk("sta_flags", {12'h0, alu_flags}, 16'h0000);
      step();
      dm_store = 1'b0; alu_store = 1'b0; im_address = 10'd6; #1;
      chk("lda_dm1", dm_out, 16'd10);

      // push then pop
      sp = 16'h01FF; dm_wsel = 1'b1; dm_wdata = 16'd3; dm_push = 1'b1;
      step();
      dm_push = 1'b0; dm_pop = 1'b1; #1;
      chk("pop_1ff", dm_out, 16'd3);

      // push + store together: only stack slot written
      dm_pop = 1'b0; sp = 16'h01FE; im_address = 10'd5; dm_wdata = 16'h1234;
      dm_push = 1'b1; dm_store = 1'b1;
      step();
      dm_push = 1'b0; dm_store = 1'b0; dm_pop = 1'b1; #1;
      chk("pushstore_sp", dm_out, 16'h1234);
      dm_pop = 1'b0; im_address = 10'd6; #1;
      chk("pushstore_dm1", dm_out, 16'd10);

      // push + pop same cycle, with upper sp bits ignored
      sp = 16'hFFFF; dm_pop = 1'b1; dm_push = 1'b1; dm_wdata = 16'h0055; #1;
      chk("pushpop_old", dm_out, 16'd3);
      step();
      dm_push = 1'b0; #1;
      chk("pushpop_new", dm_out, 16'h0055);
      dm_pop = 1'b0; dm_wsel = 1'b0;

      // ADD overflow, SUB borrow
      im_address = 10'd7; alu_a = 16'h7FFF; #1;
      chk("add_out", alu_out, 16'h8000);
      chk("add_flags", {12'h0, alu_flags}, 16'h0005);
      im_address = 10'd8; alu_a = 16'h0000; #1;
      chk("sub_out", alu_out, 16'hFFFF);
      chk("sub_flags", {12'h0, alu_flags}, 16'h0006);
      step();
      chk("flags_q_sub", {12'h0, alu_flags_q}, 16'h0006);

      // store pass-through and non-ALU opcode leave flags_q alone
      alu_store = 1'b1; #1;
      chk("store_flags", {12'h0, alu_flags}, 16'h0008);
      step();
      chk("flags_q_hold_st", {12'h0, alu_flags_q}, 16'h0006);
      alu_store = 1'b0; im_address = 10'd11; alu_a = 16'd5; #1;
      chk("op0_out", alu_out, 16'h0000);
      chk("op0_flags", {12'h0, alu_flags}, 16'h0008);
      step();
      chk("flags_q_hold_op", {12'h0, alu_flags_q}, 16'h0006);

      // shift opcodes
      im_address = 10'd9; alu_a = 16'h2001; #1;
`ifdef ALU_SHIFT_EN
      chk("lsl_out", alu_out, 16'h0008);
      chk("lsl_flags", {12'h0, alu_flags}, 16'h0002);
`else
      chk("lsl_out", alu_out, 16'h0000);
      chk("lsl_flags", {12'h0, alu_flags}, 16'h0008);
`endif
      im_address = 10'd10; alu_a = 16'h0006; #1;
`ifdef ALU_SHIFT_EN
      chk("lsr_out", alu_out, 16'h0001);
      chk("lsr_flags", {12'h0, alu_flags}, 16'h0002);
`else
      chk("lsr_out", alu_out, 16'h0000);
      chk("lsr_flags", {12'h0, alu_flags}, 16'h0008);
`endif

      // reset mid-run: DM[5]=7, flags_q nonzero
      im_address = 10'd8; alu_a = 16'h0000;
      sp = 16'h0005; dm_wsel = 1'b1; dm_wdata = 16'd7; dm_push = 1'b1;
      step();
      dm_push = 1'b0; dm_pop = 1'b1; #1;
      chk("dm5_written", dm_out, 16'd7);
      chk("flags_q_pre", {12'h0, alu_flags_q}, 16'h0006);
      reset_n = 1'b0; #1;
      chk("rst_dm5", dm_out, 16'h0000);
      chk("rst_flags_q", {12'h0, alu_flags_q}, 16'h0000);
      sp = 16'h01FF; #1;
      chk("rst_dm1ff", dm_out, 16'h0000);
      // writes blocked while held in reset
      sp = 16'h0005; dm_wdata = 16'd9; dm_push = 1'b1;
      step();
      dm_push = 1'b0;
      chk("rst_no_write", dm_out, 16'h0000);
      chk("rst_flags_hold", {12'h0, alu_flags_q}, 16'h0000);
      reset_n = 1'b1; dm_pop = 1'b0;
      im_address = 10'd4; #1;
      chk("im_kept4", instruction, 16'h5808);
      im_address = 10'd0; #1;
      chk("im_kept0", instruction, 16'h400A);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
